// File: rtl/code_word_decoder.sv
// rtl/code_word_decoder.sv - rebuilds 32-bit words from 12-bit match codes and split literals
module code_word_decoder #(
  parameter int WIDTH = 32,
  parameter int IN_W  = 16,
  parameter int RUN_W = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  input  logic [IN_W-1:0]  i_data,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_word,
  input  logic             i_ready,
  output logic             o_busy,
  output logic             o_error
);

  typedef enum logic [1:0] {S_CODE, S_LIT_HI, S_LIT_LO, S_RUN} state_t;

  state_t           state;
  logic [RUN_W-1:0] run_cnt;
  logic [IN_W-1:0]  lit_hi;
  logic             slot_free;
  logic             accept;
  logic [11:0]      code;

  assign slot_free = ~o_valid | i_ready;
  assign accept    = i_valid & o_ready;
  assign code      = i_data[11:0];
  assign o_busy    = (state != S_CODE) | o_valid;

  // The high literal half never emits, so it is taken even while the slot is full.
  always_comb begin
    o_ready = 1'b0;
    case (state)
      S_CODE:   o_ready = slot_free;
      S_LIT_HI: o_ready = 1'b1;
      S_LIT_LO: o_ready = slot_free;
      S_RUN:    o_ready = 1'b0;
      default:  o_ready = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= S_CODE;
      o_valid <= 1'b0;
      o_word  <= '0;
      o_error <= 1'b0;
      run_cnt <= '0;
      lit_hi  <= '0;
    end else begin
      if (i_ready) o_valid <= 1'b0;
      case (state)
        S_CODE: begin
          if (accept) begin
            if (code == 12'h000) begin
              o_valid <= 1'b1;
              o_word  <= '0;
            end else begin
              case (code[11:8])
                4'hD: begin
                  o_valid <= 1'b1;
                  o_word  <= WIDTH'(code[7:0]);
                end
                4'hE: begin
                  o_valid <= 1'b1;
                  o_word  <= '0;
                  run_cnt <= RUN_W'(code[7:0]);
                  if (code[7:0] != 8'h00) state <= S_RUN;
                end
                4'hF:    state   <= S_LIT_HI;
                default: o_error <= 1'b1;
              endcase
            end
          end
        end
        S_LIT_HI: begin
          if (accept) begin
            lit_hi <= i_data;
            state  <= S_LIT_LO;
          end
        end
        S_LIT_LO: begin
          if (accept) begin
            o_valid <= 1'b1;
            o_word  <= {lit_hi, i_data};
            state   <= S_CODE;
          end
        end
        S_RUN: begin
          if (slot_free) begin
            o_valid <= 1'b1;
            o_word  <= '0;
            run_cnt <= run_cnt - RUN_W'(1);
            if (run_cnt == RUN_W'(1)) state <= S_CODE;
          end
        end
        default: state <= S_CODE;
      endcase
    end
  end

endmodule

// File: tb/tb_code_word_decoder.sv
// tb/tb_code_word_decoder.sv - randomized bench for code_word_decoder against a token-level model
module tb_code_word_decoder;

  logic        i_clk = 1'b0;
  logic        i_reset, i_valid, i_ready;
  logic [15:0] i_data;
  logic        o_ready, o_valid, o_busy, o_error;
  logic [31:0] o_word;

  code_word_decoder dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_data(i_data),
    .o_ready(o_ready), .o_valid(o_valid), .o_word(o_word), .i_ready(i_ready),
    .o_busy(o_busy), .o_error(o_error)
  );

  always #5 i_clk = ~i_clk;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] beats[$];
  int          kind[$];   // 0 = code beat, 1 = literal high half, 2 = literal low half
  logic [31:0] expq[$];
  logic        exp_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model();
    int i = 0;
    logic [11:0] c;
    kind.delete();
    expq.delete();
    while (i < beats.size()) begin
      c = beats[i][11:0];
      kind.push_back(0);
      if (c == 12'h000) expq.push_back(32'h0);
      else if (c[11:8] == 4'hD) expq.push_back({24'h0, c[7:0]});
      else if (c[11:8] == 4'hE) begin
        for (int k = 0; k <= int'(c[7:0]); k++) expq.push_back(32'h0);
      end else if (c[11:8] == 4'hF) begin
        kind.push_back(1);
        kind.push_back(2);
        expq.push_back({beats[i+1], beats[i+2]});
        i += 2;
      end else exp_err = 1'b1;
      i++;
    end
  endtask

  task automatic do_reset();
    i_reset = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_data = 16'h0;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    exp_err = 1'b0;
  endtask

  task automatic run_stream(input int vpct, input int rpct);
    int          bi = 0;
    int          pending_run = 0;
    bit          prev_stall = 0;
    bit          done = 0;
    logic [31:0] prev_word = '0;
    model();
    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      i_valid = (bi < beats.size()) && ($urandom_range(1, 100) <= vpct);
      i_data  = i_valid ? beats[bi] : 16'($urandom);
      i_ready = ($urandom_range(1, 100) <= rpct);
      @(negedge i_clk);
      if (prev_stall) begin
        check("stall_valid", {31'h0, o_valid}, 32'h1);
        check("stall_word", o_word, prev_word);
      end
      if (pending_run > 0) begin
        check("run_ready", {31'h0, o_ready}, 32'h0);
        if (!o_valid || i_ready) pending_run--;
      end else if (i_valid && kind[bi] == 1) begin
        check("lit_hi_ready", {31'h0, o_ready}, 32'h1);
      end
      if (o_valid && i_ready) begin
        if (expq.size() == 0) check("extra_word", o_word, 32'hxxxxxxxx);
        else check("word", o_word, expq.pop_front());
      end
      prev_stall = o_valid && !i_ready;
      prev_word  = o_word;
      if (i_valid && o_ready) begin
        if (kind[bi] == 0 && beats[bi][11:8] == 4'hE && beats[bi][11:0] != 12'h0)
          pending_run = int'(beats[bi][7:0]);
        bi++;
      end
      @(posedge i_clk); #1;
      done = (bi == beats.size()) && (expq.size() == 0) && (pending_run == 0);
    end
    if (!done) check("timeout", 32'h0, 32'h1);
    i_valid = 1'b0;
    i_ready = 1'b1;
    repeat (3) begin
      @(negedge i_clk);
      check("idle_valid", {31'h0, o_valid}, 32'h0);
      @(posedge i_clk); #1;
    end
    check("error", {31'h0, o_error}, {31'h0, exp_err});
    check("busy_idle", {31'h0, o_busy}, 32'h0);
    beats.delete();
  endtask

  task automatic add_token();
    int r = $urandom_range(0, 9);
    case (r)
      0, 1: beats.push_back({4'($urandom), 12'h000});
      2, 3: beats.push_back({4'($urandom), 4'hD, 8'($urandom)});
      4:    beats.push_back({4'($urandom), 4'hE, 8'($urandom_range(0, 5))});
      5:    beats.push_back({4'($urandom), 4'hE, 8'($urandom_range(0, 40))});
      6, 7: begin
        beats.push_back({4'($urandom), 12'hF00 | 12'($urandom_range(0, 255))});
        beats.push_back(($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom));
        beats.push_back(($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom));
      end
      default: beats.push_back({4'($urandom), 4'($urandom_range(0, 12)), 8'($urandom_range(1, 255))});
    endcase
  endtask

  initial begin
    do_reset();
    @(negedge i_clk);
    check("rst_valid", {31'h0, o_valid}, 32'h0);
    check("rst_word", o_word, 32'h0);
    check("rst_error", {31'h0, o_error}, 32'h0);
    check("rst_busy", {31'h0, o_busy}, 32'h0);
    check("rst_ready", {31'h0, o_ready}, 32'h1);
    @(posedge i_clk); #1;

    beats = '{16'h0000, 16'h0D5A};          run_stream(100, 100);
    beats = '{16'h0F00, 16'hDEAD, 16'hBEEF}; run_stream(100, 100);
    beats = '{16'h0E03, 16'h0D01};           run_stream(100, 50);
    beats = '{16'h0E00};                     run_stream(100, 100);
    beats = '{16'h0EFF};                     run_stream(100, 100);
    beats = '{16'h0A12, 16'h0D07};           run_stream(100, 70);

    // Reset in the middle of a literal drops the half already taken.
    i_valid = 1'b1; i_ready = 1'b1; i_data = 16'h0F00;
    @(posedge i_clk); #1;
    i_data = 16'h1234;
    @(posedge i_clk); #1;
    do_reset();
    @(negedge i_clk);
    check("lit_rst_valid", {31'h0, o_valid}, 32'h0);
    check("lit_rst_error", {31'h0, o_error}, 32'h0);
    @(posedge i_clk); #1;
    beats = '{16'h0D09}; run_stream(100, 100);

    // Reset in the middle of a run discards the remaining zeros.
    i_valid = 1'b1; i_ready = 1'b1; i_data = 16'h0EFF;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (5) @(posedge i_clk);
    #1;
    do_reset();
    @(negedge i_clk);
    check("run_rst_valid", {31'h0, o_valid}, 32'h0);
    check("run_rst_busy", {31'h0, o_busy}, 32'h0);
    @(posedge i_clk); #1;

    for (int s = 0; s < 20; s++) begin
      for (int t = 0; t < 30; t++) add_token();
      run_stream($urandom_range(30, 100), $urandom_range(30, 100));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/code_word_decoder.md
Name: code_word_decoder

Overview:
- Decompression-side counterpart of the word-match comparator stage: turns the 12-bit match codes the compressor emits back into 32-bit data words.
- Consumes a 16-bit beat stream carrying zero codes, low-byte codes, zero-run codes and split literals, and produces one reconstructed word per output handshake.
- Sits between the decompressor's bit-unpacker (upstream) and the output word FIFO (downstream).

Parameters:
- WIDTH, 32, reconstructed word width; only 32 is supported.
- IN_W, 16, input beat width; a literal is carried as exactly two beats.
- RUN_W, 8, zero-run length field width; a run emits up to 2^RUN_W words.

Ports:
- i_clk  input  1  clock
- i_reset  input  1  synchronous, active-high reset
- i_valid  input  1  upstream beat valid
- i_data  input  IN_W  beat: code in [11:0] ([15:12] ignored), or literal half
- o_ready  output  1  beat accepted this cycle when i_valid & o_ready
- o_valid  output  1  o_word valid
- o_word  output  WIDTH  reconstructed word
- i_ready  input  1  downstream accepts o_word when o_valid & i_ready
- o_busy  output  1  FSM not in S_CODE, or o_valid high
- o_error  output  1  sticky illegal-code flag

Behaviour:
- Reset (i_reset=1 at posedge): state=S_CODE, o_valid=0, o_word=0, o_error=0, run counter=0, literal-high register=0. Applies mid-literal and mid-run: the partial literal and the remaining run are discarded.
- Output slot: single registered entry. slot_free = ~o_valid | i_ready.
- Code decode in S_CODE, on accepted beat, using c=i_data[11:0]:
  - c==12'h000: emit 32'h0.
  - c[11:8]==4'b1101: emit {24'h0, c[7:0]}.
  - c[11:8]==4'b1110: zero-run. Emit 32'h0 now, load run counter with c[7:0], go to S_RUN. Total zeros emitted = c[7:0]+1, range 1..256.
  - c[11:8]==4'b1111: literal marker. Emit nothing, go to S_LIT_HI.
  - Any other c: set o_error=1, drop the beat, emit nothing, stay in S_CODE.
- S_LIT_HI: the next accepted beat is stored as word[31:16]; go to S_LIT_LO.
- S_LIT_LO: on the next accepted beat, emit {hi, i_data}; go to S_CODE. Literal beats are never decoded as codes; 16'h0000 is legal data.
- S_RUN: o_ready=0. Each time slot_free, emit 32'h0 and decrement the counter. Leave for S_CODE on the cycle the counter goes from 1 to 0 as that word is emitted. A run with c[7:0]=0 never enters S_RUN.
- o_ready:
  - S_LIT_HI: 1.
  - S_CODE and S_LIT_LO: slot_free.
  - S_RUN: 0.
  - S_CODE accepts a literal-marker beat or an illegal beat only when slot_free; the rule is kept uniform.
- Latency: a word appears on o_word/o_valid the cycle after the beat that produces it is accepted. Back-to-back throughput is 1 word/cycle while i_ready=1. A literal costs 2 beats after its marker.
- Stall: while o_valid & ~i_ready, o_word and o_valid hold stable and no emission occurs.
- Simultaneous drain and refill: on a cycle with o_valid & i_ready and a new emission, o_valid stays 1 and o_word takes the new value.
- o_error clears only on reset. Decoding continues after an error.

Test Plan:
- Reset, then beats 16'h0000, 16'h0D5A with i_ready=1 -> o_word 32'h00000000 then 32'h0000005A on consecutive cycles; o_error=0.
- Beats 16'h0F00, 16'hDEAD, 16'hBEEF -> exactly one word 32'hDEADBEEF, one cycle after the 16'hBEEF beat is accepted; o_ready=1 during the marker.
- Beat 16'h0E03 then 16'h0D01, with i_ready toggling 1,0,1,1,0,1 -> four 32'h0 words, then 32'h00000001. o_ready=0 while counting; o_word stable during every stall.
- Beat 16'h0E00 -> exactly one 32'h0. Beat 16'h0EFF with i_ready=1 -> 256 consecutive 32'h0 words, then S_CODE.
- Beat 16'h0A12 -> o_error=1, no word emitted. A following beat 16'h0D07 -> 32'h00000007; o_error stays 1.
- Beats 16'h0F00, 16'h1234, then i_reset=1 for one cycle, then 16'h0D09 -> only 32'h00000009 emitted; o_error=0; the pending literal is lost.
